// File: rtl/ahb5_subordinate_mem.sv
// AHB5 subordinate memory: MEM_DEPTH x DATA_WIDTH words, pipelined address/data phase, two-cycle ERROR.
// Define AHB_WAIT_STATE_EN to insert WAIT_CYCLES wait states before every valid data phase.
module ahb5_subordinate_mem #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned MEM_DEPTH   = 64,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  HSEL,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [DATA_WIDTH-1:0] HWDATA,
   input  logic                  HREADY,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic [DATA_WIDTH-1:0] HRDATA
);

   localparam int unsigned OFFSET = $clog2(MEM_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(MEM_DEPTH * 4);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

   state_t                state_q, state_d;
   logic [OFFSET+1:0]     addr_q;
   logic                  write_q;
   logic [1:0]            size_q;
   logic [3:0]            be;
   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
   logic                  can_accept, take, addr_err;
   state_t                valid_next;
   logic                  unused;

   assign unused = &{1'b0, HTRANS[0]};

   // Accepts are only honoured in states that drive HREADYOUT high.
   assign can_accept = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
   assign take       = can_accept && HSEL && HREADY && HTRANS[1];

   assign addr_err = (HADDR >= LIMIT) || (HSIZE > 3'b010) ||
                     ((HSIZE == 3'b001) && HADDR[0]) ||
                     ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));

`ifdef AHB_WAIT_STATE_EN
   localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
   logic [CW-1:0] wait_cnt;

   assign valid_next = (WAIT_CYCLES > 0) ? S_WAIT : S_DATA;

   always_ff @(posedge HCLK) begin
      if (HRESET)
         wait_cnt <= '0;
      else if (take)
         wait_cnt <= CNT_LOAD;
      else if ((state_q == S_WAIT) && (wait_cnt != '0))
         wait_cnt <= wait_cnt - 1'b1;
   end
`else
   localparam int unsigned unused_wait = WAIT_CYCLES;
   assign valid_next = S_DATA;
`endif

   always_comb begin
      state_d   = state_q;
      HREADYOUT = 1'b1;
      HRESP     = 1'b0;
      case (state_q)
         S_IDLE, S_DATA, S_ERR2: begin
            HRESP   = (state_q == S_ERR2);
            state_d = S_IDLE;
            if (take) state_d = addr_err ? S_ERR1 : valid_next;
         end
`ifdef AHB_WAIT_STATE_EN
         S_WAIT: begin
            HREADYOUT = 1'b0;
            if (wait_cnt == '0) state_d = S_DATA;
         end
`endif
         S_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = 1'b1;
            state_d   = S_ERR2;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      be = '0;
      case (size_q)
         2'b00:   be[addr_q[1:0]] = 1'b1;
         2'b01:   be = addr_q[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
   end

   assign HRDATA = ((state_q == S_DATA) && !write_q) ? mem[addr_q[OFFSET+1:2]] : '0;

   // Write commit uses the registered address; a new accept in the same cycle only updates addr_q afterwards.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         write_q <= 1'b0;
         size_q  <= '0;
         for (int unsigned i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
      end else begin
         state_q <= state_d;
         if (take) begin
            addr_q  <= HADDR[OFFSET+1:0];
            write_q <= HWRITE;
            size_q  <= HSIZE[1:0];
         end
         if ((state_q == S_DATA) && write_q) begin
            for (int unsigned i = 0; i < 4; i++)
               if (be[i]) mem[addr_q[OFFSET+1:2]][8*i +: 8] <= HWDATA[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_ahb5_subordinate_mem.sv
// Directed self-checking bench for ahb5_subordinate_mem; HREADY is looped back from HREADYOUT.
module tb_ahb5_subordinate_mem;

`ifdef AHB_WAIT_STATE_EN
   localparam int EXP_WAITS = 2;
`else
   localparam int EXP_WAITS = 0;
`endif

   logic        hclk = 1'b0;
   logic        hreset, hsel, hwrite;
   logic [31:0] haddr, hwdata, hrdata;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic        hready, hreadyout, hresp;

   int errors = 0;
   int checks = 0;

   always #5 hclk = ~hclk;
   assign hready = hreadyout;

   ahb5_subordinate_mem #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(64), .WAIT_CYCLES(2)
   ) dut (
      .HCLK(hclk), .HRESET(hreset), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
      .HREADYOUT(hreadyout), .HRESP(hresp), .HRDATA(hrdata)
   );

   // Single transfer: address phase, then data phase until HREADYOUT=1 (bounded).
   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wd, output logic [31:0] rd, output logic resp,
                       output int waits, output logic first_rdy, output logic first_resp);
      logic done, first;
      done = 1'b0; first = 1'b1; waits = 0;
      rd = 'x; resp = 1'bx; first_rdy = 1'bx; first_resp = 1'bx;
      @(negedge hclk);
      hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = size;
      @(posedge hclk); #1;
      hsel = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0; hsize = 3'b000; hwdata = wd;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge hclk);
         if (first) begin first_rdy = hreadyout; first_resp = hresp; first = 1'b0; end
         if (hreadyout) begin rd = hrdata; resp = hresp; done = 1'b1; end
         else waits++;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL xfer_timeout addr=%h got no HREADYOUT within 20 cycles", addr);
      end
      @(posedge hclk); #1;
      hwdata = '0;
   endtask

   task automatic do_reset();
      @(negedge hclk); hreset = 1'b1;
      repeat (2) @(posedge hclk);
      #1 hreset = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] rd; logic resp, fr, fs; int w;
      do_reset();
      xfer(1'b1, 32'h0, 3'b010, 32'hCAFEF00D, rd, resp, w, fr, fs);
      do_reset();
      @(negedge hclk);
      checks++; if (hreadyout !== 1'b1) begin errors++; $display("FAIL reset_hreadyout got=%b exp=1", hreadyout); end
      checks++; if (hresp !== 1'b0) begin errors++; $display("FAIL reset_hresp got=%b exp=0", hresp); end
      checks++; if (hrdata !== 32'h0) begin errors++; $display("FAIL reset_hrdata got=%h exp=00000000", hrdata); end
      xfer(1'b0, 32'h0, 3'b010, 32'h0, rd, resp, w, fr, fs);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_mem_cleared got=%h exp=00000000", rd); end
   endtask

   task automatic test_word();
      logic [31:0] rd; logic resp, fr, fs; int w;
      xfer(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, rd, resp, w, fr, fs);
      checks++; if (w !== EXP_WAITS) begin errors++; $display("FAIL word_write_waits got=%0d exp=%0d", w, EXP_WAITS); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL write_hrdata_zero got=%h exp=00000000", rd); end
      checks++; if (resp !== 1'b0) begin errors++; $display("FAIL word_write_resp got=%b exp=0", resp); end
      xfer(1'b0, 32'h10, 3'b010, 32'h0, rd, resp, w, fr, fs);
      checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL word_read got=%h exp=deadbeef", rd); end
      checks++; if (resp !== 1'b0) begin errors++; $display("FAIL word_read_resp got=%b exp=0", resp); end
      checks++; if (w !== EXP_WAITS) begin errors++; $display("FAIL word_read_waits got=%0d exp=%0d", w, EXP_WAITS); end
   endtask

   task automatic test_byte_lanes();
      logic [31:0] rd; logic resp, fr, fs; int w;
      xfer(1'b1, 32'h20, 3'b010, 32'h0, rd, resp, w, fr, fs);
      xfer(1'b1, 32'h21, 3'b000, 32'h0000AB00, rd, resp, w, fr, fs);
      xfer(1'b1, 32'h22, 3'b001, 32'h12340000, rd, resp, w, fr, fs);
      xfer(1'b0, 32'h20, 3'b010, 32'h0, rd, resp, w, fr, fs);
      checks++; if (rd !== 32'h1234AB00) begin errors++; $display("FAIL byte_lanes got=%h exp=1234ab00", rd); end
      xfer(1'b1, 32'h23, 3'b000, 32'hCDFFFFFF, rd, resp, w, fr, fs);
      xfer(1'b1, 32'h20, 3'b001, 32'hFFFF5678, rd, resp, w, fr, fs);
      xfer(1'b0, 32'h20, 3'b010, 32'h0, rd, resp, w, fr, fs);
      checks++; if (rd !== 32'hCD345678) begin errors++; $display("FAIL byte_lanes2 got=%h exp=cd345678", rd); end
   endtask

   task automatic test_out_of_range();
      logic [31:0] rd; logic resp, fr, fs; int w;
      xfer(1'b1, 32'h0, 3'b010, 32'hA5A5A5A5, rd, resp, w, fr, fs);
      xfer(1'b0, 32'h100, 3'b010, 32'h0, rd, resp, w, fr, fs);
      checks++; if ({fr, fs} !== 2'b01) begin errors++; $display("FAIL oob_first_cycle got=%b%b exp=01", fr, fs); end
      checks++; if ({1'b1, resp} !== 2'b11 || w !== 1) begin errors++; $display("FAIL oob_second_cycle got resp=%b waits=%0d exp resp=1 waits=1", resp, w); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oob_hrdata got=%h exp=00000000", rd); end
      xfer(1'b1, 32'h100, 3'b010, 32'h55555555, rd, resp, w, fr, fs);
      checks++; if (resp !== 1'b1) begin errors++; $display("FAIL oob_write_resp got=%b exp=1", resp); end
      xfer(1'b0, 32'h0, 3'b010, 32'h0, rd, resp, w, fr, fs);
      checks++; if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL oob_mem_unchanged got=%h exp=a5a5a5a5", rd); end
   endtask

   task automatic test_misaligned();
      logic [31:0] rd; logic resp, fr, fs; int w;
      xfer(1'b1, 32'h04, 3'b010, 32'h11223344, rd, resp, w, fr, fs);
      xfer(1'b1, 32'h06, 3'b010, 32'hFFFFFFFF, rd, resp, w, fr, fs);
      checks++; if ({fr, fs, resp} !== 3'b011 || w !== 1) begin errors++; $display("FAIL misaligned_word got=%b%b%b waits=%0d exp=011 waits=1", fr, fs, resp, w); end
      xfer(1'b1, 32'h05, 3'b001, 32'hFFFFFFFF, rd, resp, w, fr, fs);
      checks++; if ({fr, fs, resp} !== 3'b011) begin errors++; $display("FAIL misaligned_half got=%b%b%b exp=011", fr, fs, resp); end
      xfer(1'b1, 32'h04, 3'b011, 32'hFFFFFFFF, rd, resp, w, fr, fs);
      checks++; if ({fr, fs, resp} !== 3'b011) begin errors++; $display("FAIL bad_hsize got=%b%b%b exp=011", fr, fs, resp); end
      xfer(1'b0, 32'h04, 3'b010, 32'h0, rd, resp, w, fr, fs);
      checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL misaligned_mem_unchanged got=%h exp=11223344", rd); end
      checks++; if (resp !== 1'b0) begin errors++; $display("FAIL after_error_resp got=%b exp=0", resp); end
   endtask

   // Pipelined NONSEQ+SEQ writes; counts HREADYOUT=0 cycles in each data phase.
   task automatic test_back_to_back();
      logic [31:0] rd; logic resp, fr, fs; int w, wa, wb; logic da, db;
      da = 1'b0; db = 1'b0; wa = 0; wb = 0;
      @(negedge hclk);
      hsel = 1'b1; htrans = 2'b10; haddr = 32'h0; hwrite = 1'b1; hsize = 3'b010;
      @(posedge hclk); #1;
      hwdata = 32'h0BADF00D; htrans = 2'b11; haddr = 32'h4;
      for (int i = 0; i < 20 && !da; i++) begin
         @(negedge hclk);
         if (hreadyout) da = 1'b1; else wa++;
      end
      @(posedge hclk); #1;
      hwdata = 32'hFEEDFACE; hsel = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0;
      for (int i = 0; i < 20 && !db; i++) begin
         @(negedge hclk);
         if (hreadyout) db = 1'b1; else wb++;
      end
      @(posedge hclk); #1;
      hwdata = '0;
      checks++; if (!da || wa !== EXP_WAITS) begin errors++; $display("FAIL b2b_first_waits got=%0d done=%b exp=%0d", wa, da, EXP_WAITS); end
      checks++; if (!db || wb !== EXP_WAITS) begin errors++; $display("FAIL b2b_second_waits got=%0d done=%b exp=%0d", wb, db, EXP_WAITS); end
      xfer(1'b0, 32'h0, 3'b010, 32'h0, rd, resp, w, fr, fs);
      checks++; if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL b2b_word0 got=%h exp=0badf00d", rd); end
      xfer(1'b0, 32'h4, 3'b010, 32'h0, rd, resp, w, fr, fs);
      checks++; if (rd !== 32'hFEEDFACE) begin errors++; $display("FAIL b2b_word1 got=%h exp=feedface", rd); end
   endtask

   initial begin
      hreset = 1'b1; hsel = 1'b0; htrans = 2'b00; haddr = '0;
      hwrite = 1'b0; hsize = 3'b000; hwdata = '0;
      test_reset();
      test_word();
      test_byte_lanes();
      test_out_of_range();
      test_misaligned();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
